// File: rtl/serial_pkg.sv
// Shared serial-line package: FSM state type and line levels, common to tx and rx.
// Defining SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_pkg;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

endpackage

// File: rtl/serial_tx_if.sv
// Load channel into the serial transmitter: data_in, load_valid, load_ready.
// master = producer (drives data_in/load_valid), slave = transmitter (drives load_ready).
interface serial_tx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data_in;
    logic              load_valid;
    logic              load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles while en is high; bit_tick marks the last cycle of a bit.
// Ports: clk, rst (sync, active-high), en (count enable; low clears), bit_tick (one-cycle pulse).
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = en && (cnt == LAST);

    // Counter restarts at every bit boundary, so it never passes LAST.
    always_ff @(posedge clk) begin
        if (rst || !en || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: loads a DATA_W payload and sends start, data (LSB first), [parity], stop.
// Ports: clk, rst (sync, active-high), load (serial_tx_if.slave), tx_out, busy, done.
// Defining SERIAL_TX_PARITY_EN adds an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  load,
    output logic        tx_out,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_d;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_d;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_d;
    logic              tx_d;
    logic              done_d;
    logic              bit_tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              par;
    logic              par_d;
`endif

    assign load.load_ready = (state == IDLE);
    assign busy            = (state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par;
`endif
        unique case (state)
            IDLE: begin
                if (load.load_valid) begin
                    state_d   = START;
                    shreg_d   = load.data_in;
                    bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = ^load.data_in;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx_out is registered from the next state, so the start bit
    // appears in the cycle right after the accepting edge.
    always_comb begin
        tx_d = LINE_IDLE;
        unique case (state_d)
            IDLE:    tx_d = LINE_IDLE;
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = STOP_BIT;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_out  <= LINE_IDLE;
            done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            tx_out  <= tx_d;
            done    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: frame-level model predicts every line cycle.
// Honours SERIAL_TX_PARITY_EN when defined for the build.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L  = (DW + 2 + PB) * CPB;
    localparam int L1 = (1 + 2 + PB) * 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_tx_if #(.DATA_W(DW)) lif ();
    serial_tx_if #(.DATA_W(1))  lif1 ();

    logic tx, busy, done;
    logic tx1, busy1, done1;

    serial_tx #(
        .DATA_W(DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (lif),
        .tx_out(tx),
        .busy  (busy),
        .done  (done)
    );

    serial_tx #(
        .DATA_W(1),
        .CLKS_PER_BIT(1)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .load  (lif1),
        .tx_out(tx1),
        .busy  (busy1),
        .done  (done1)
    );

    typedef struct {
        logic [15:0] data;
        int          start;
    } frame_t;

    frame_t q[$];
    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int next_free = 0;
    int accepted  = 0;
    bit mon_on    = 0;

    // Bit i of a frame: start, DW payload bits LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [15:0] d,
                                       input int i, input int dw);
        if (i == 0) return 1'b0;
        if (i <= dw) return d[i-1];
        if (PB == 1 && i == dw + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act,
                       input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b",
                     name, cyc, act, exp);
        end
    endtask

    // One clock edge; the model decides what the edge does.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            next_free = cyc + 1;
        end else if (lif.load_valid && cyc >= next_free) begin
            q.push_back('{data: 16'(lif.data_in), start: cyc});
            next_free = cyc + L + 1;
            accepted++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [DW-1:0] d);
        lif.data_in    = d;
        lif.load_valid = 1'b1;
        step();
        lif.load_valid = 1'b0;
    endtask

    // Monitor: expected line state from the head of the scoreboard.
    logic e_tx, e_busy, e_done;
    int   off;
    always @(negedge clk) begin
        if (mon_on) begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (q.size() > 0 && cyc >= q[0].start) begin
                off = cyc - q[0].start;
                if (off < L) begin
                    e_tx   = frame_bit(q[0].data, off / CPB, DW);
                    e_busy = 1'b1;
                end else begin
                    e_done = 1'b1;
                    void'(q.pop_front());
                end
            end
            chk("tx_out", tx, e_tx);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("load_ready", lif.load_ready, !e_busy);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int guard;
        lif.data_in     = '0;
        lif.load_valid  = 1'b0;
        lif1.data_in    = '0;
        lif1.load_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        mon_on = 1'b1;
        idle(3);

        send(8'hA5);
        idle(L + 5);
        send(8'h07);
        idle(L + 5);

        // valid held high across two frames
        a0 = accepted;
        lif.data_in    = 8'h3C;
        lif.load_valid = 1'b1;
        step();
        lif.data_in = 8'hC3;
        guard = 0;
        while (accepted < a0 + 2 && guard < L + 10) begin
            step();
            guard++;
        end
        lif.load_valid = 1'b0;
        chk("b2b_accepts", accepted == a0 + 2, 1'b1);
        idle(L + 5);

        // load attempt mid-frame is ignored
        send(8'h00);
        idle(3 * CPB);
        send(8'hFF);
        idle(L + 5);

        // reset during DATA aborts the frame
        send(8'h5A);
        idle(4 * CPB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(L + 5);

        // reset wins over a simultaneous load
        rst            = 1'b1;
        lif.data_in    = 8'h55;
        lif.load_valid = 1'b1;
        step();
        rst            = 1'b0;
        lif.load_valid = 1'b0;
        idle(5);

        repeat (600) begin
            lif.load_valid = ($urandom_range(0, 3) == 0);
            lif.data_in    = 8'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst            = 1'b0;
        lif.load_valid = 1'b0;
        idle(L + 5);

        // single-bit payload, one cycle per bit
        for (int v = 1; v >= 0; v--) begin
            @(negedge clk);
            chk("w1_ready", lif1.load_ready, 1'b1);
            lif1.data_in    = 1'(v);
            lif1.load_valid = 1'b1;
            step();
            lif1.load_valid = 1'b0;
            for (int i = 0; i <= L1; i++) begin
                @(negedge clk);
                chk("w1_tx", tx1,
                    (i < L1) ? frame_bit(16'(v), i, 1) : 1'b1);
                chk("w1_busy", busy1, i < L1);
                chk("w1_done", done1, i == L1);
                step();
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
